// File: rtl/multi_key_led_pkg.sv
// Shared types and constants for the multi-key LED controller.
package multi_key_led_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_t;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned KEY_ADD  = 0;
  localparam int unsigned KEY_SUB  = 1;
  localparam int unsigned KEY_SHL  = 2;
  localparam int unsigned KEY_SHR  = 3;

  // Counters only ever hold values up to (limit - 1), so clog2 of the largest limit suffices.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/multi_key_led_key_debounce_rep.sv
// One key channel: 2-flop synchronizer, debounce FSM and auto-repeat event generator.
module key_debounce_rep
  import multi_key_led_pkg::*;
#(
  parameter int unsigned DB_CYC  = 1000000,
  parameter int unsigned REP_DLY = 25000000,
  parameter int unsigned REP_PER = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic evt,
  output logic held
);

  localparam int unsigned   CW       = cnt_width(DB_CYC, REP_DLY, REP_PER);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 1);
  localparam bit            REP_EN   = (REP_DLY > 0);

  logic [1:0]    sync;
  logic          key_low;
  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rep_armed, rep_armed_nxt;
  logic          evt_nxt;

  assign key_low = ~sync[1];
  assign held    = (state == HELD) || (state == REL_DB);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      rep_armed <= 1'b0;
      evt       <= 1'b0;
    end else begin
      sync      <= {sync[0], key};
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rep_armed <= rep_armed_nxt;
      evt       <= evt_nxt;
    end
  end

  // cnt is the debounce count in PRESS_DB/REL_DB and the repeat count in HELD.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rep_armed_nxt = rep_armed;
    evt_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (key_low) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (!key_low) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt     = HELD;
          cnt_nxt       = '0;
          rep_armed_nxt = 1'b0;
          evt_nxt       = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!key_low) begin
          state_nxt = REL_DB;
          cnt_nxt   = '0;
        end else if (REP_EN) begin
          // First repeat waits REP_DLY, later ones REP_PER.
          if (cnt == (rep_armed ? PER_LAST : DLY_LAST)) begin
            cnt_nxt       = '0;
            rep_armed_nxt = 1'b1;
            evt_nxt       = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      REL_DB: begin
        if (key_low) begin
          state_nxt     = HELD;
          cnt_nxt       = '0;
          rep_armed_nxt = 1'b0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/multi_key_led.sv
// Four debounced keys driving add/sub/shift operations on an LED register.
module multi_key_led
  import multi_key_led_pkg::*;
#(
  parameter int unsigned       LED_W    = 8,
  parameter int unsigned       DB_CYC   = 1000000,
  parameter int unsigned       REP_DLY  = 25000000,
  parameter int unsigned       REP_PER  = 5000000,
  parameter int unsigned       WRAP     = 1,
  parameter int unsigned       ROTATE   = 0,
  parameter logic [LED_W-1:0]  LED_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_in,
  output logic [LED_W-1:0] led,
  output logic [3:0]       key_evt,
  output logic [3:0]       key_held
);

  localparam logic [LED_W-1:0] ALL_ONES = '1;

  logic [LED_W-1:0] led_nxt;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_rep #(
      .DB_CYC (DB_CYC),
      .REP_DLY(REP_DLY),
      .REP_PER(REP_PER)
    ) u_key (
      .clk  (clk),
      .reset(reset),
      .key  (key_in[g]),
      .evt  (key_evt[g]),
      .held (key_held[g])
    );
  end

  // Highest-priority event wins; simultaneous lower-priority events are dropped.
  always_comb begin
    led_nxt = led;
    if (key_evt[KEY_ADD]) begin
      led_nxt = (WRAP == 0 && led == ALL_ONES) ? led : led + LED_W'(1);
    end else if (key_evt[KEY_SUB]) begin
      led_nxt = (WRAP == 0 && led == '0) ? led : led - LED_W'(1);
    end else if (key_evt[KEY_SHL]) begin
      led_nxt = {led[LED_W-2:0], (ROTATE != 0) ? led[LED_W-1] : 1'b0};
    end else if (key_evt[KEY_SHR]) begin
      led_nxt = {(ROTATE != 0) ? led[0] : 1'b0, led[LED_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= LED_INIT;
    end else begin
      led <= led_nxt;
    end
  end

endmodule
